uart_reg_bridge: RTL and testbench
==================================

// Module: uart_reg_bridge
// PURPOSE
//  Host-side command bridge: parses UART rx byte stream into register bus transactions, returns responses as bytes.
//  Is the initiator of the reg_addr/reg_wdata/reg_we/reg_re bus that uart_core and sibling peripherals respond to.
//  Sits between a uart_rx/uart_tx byte pair and the peripheral register bus; no bit-level UART logic inside.
// PARAMETERS
//  TIMEOUT_CYC  20000  max clk_i cycles between bytes within a frame before abort; 0 disables timeout
//  RD_LAT       1      cycles from reg_re pulse to valid reg_rdata (slave registers read data)
// PORTS
//  clk_i       in   1   clock, single domain
//  rst_ni      in   1   reset, asynchronous, active-low
//  rx_byte_i   in   8   received byte, valid only with rx_valid_i
//  rx_valid_i  in   1   one-cycle pulse per received byte
//  tx_byte_o   out  8   response byte to transmitter
//  tx_valid_o  out  1   response byte valid; held until accepted
//  tx_ready_i  in   1   transmitter accepts byte when high with tx_valid_o
//  reg_addr    out  12  register address
//  reg_wdata   out  32  register write data
//  reg_we      out  1   one-cycle write strobe
//  reg_re      out  1   one-cycle read strobe
//  reg_rdata   in   32  register read data, valid RD_LAT cycles after reg_re
//  busy_o      out  1   high in any state other than IDLE
//  err_o       out  1   one-cycle pulse on bad command, timeout or dropped byte
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters/shift regs cleared; reset mid-frame aborts, no reg_we/reg_re issued.
//  Frames (MSB first): write = 0x57,ADDR_HI,ADDR_LO,D3,D2,D1,D0; read = 0x52,ADDR_HI,ADDR_LO.
//  reg_addr = {ADDR_HI[3:0],ADDR_LO}; ADDR_HI[7:4] ignored. reg_wdata = {D3,D2,D1,D0}.
//  States: IDLE->ADDR_HI->ADDR_LO->(write: DATA x4 ->WRITE | read: READ->RD_WAIT)->RESP->IDLE.
//  IDLE: rx 0x57/0x52 -> ADDR_HI; any other byte -> RESP with 0x45 ('E'), err_o pulse.
//  DATA: 2-bit byte counter, shift in 4 bytes; 4th byte -> WRITE.
//  WRITE: reg_we=1 exactly one cycle, addr/wdata stable that cycle; next cycle RESP with 0x4B ('K').
//  READ: reg_re=1 exactly one cycle; RD_WAIT counts RD_LAT cycles, then captures reg_rdata into 32-bit shift reg.
//  RESP: read -> 4 bytes rdata[31:24] first; write -> 1 byte 'K'; error -> 1 byte 'E'.
//  tx handshake: byte transfers on cycle tx_valid_o&&tx_ready_i; tx_byte_o stable while tx_valid_o high and not accepted.
//  After last byte accepted: tx_valid_o=0 next cycle, FSM IDLE, busy_o=0.
//  reg_addr/reg_wdata hold last values between transactions (not cleared); reg_we/reg_re never both high.
//  rx_valid_i in WRITE/READ/RD_WAIT/RESP: byte dropped, err_o pulse, current transaction unaffected.
//  Timeout: counter cleared on each accepted byte, counts in ADDR_HI/ADDR_LO/DATA; reaching TIMEOUT_CYC ->
//   IDLE, err_o pulse, no response byte, no bus strobe. rx_valid_i on the same cycle as expiry: timeout wins, byte dropped.
//  Counter width $clog2(TIMEOUT_CYC+1), saturates; TIMEOUT_CYC=0 -> never expires.
//  err_o pulses once per event; simultaneous events give one pulse.
// TESTING
//  Write: rx 57 00 18 00 00 00 05 -> one reg_we cycle addr=0x018 wdata=0x00000005; tx 4B; busy_o low after.
//  Read: rx 52 00 08, reg_rdata=0x000000A5 at RD_LAT -> one reg_re cycle addr=0x008; tx 00 00 00 A5.
//  Bad cmd: rx 33 -> tx 45, err_o one pulse, no reg_we/reg_re; following valid frame completes normally.
//  Timeout (TIMEOUT_CYC=50): rx 57 00, idle 50 cycles -> err_o pulse, IDLE, no strobe, no tx byte.
//  Backpressure: read response with tx_ready_i low 10 cycles -> tx_byte_o=00 held stable, all 4 bytes in order after.
//  Reset mid-frame: rx 57 00 18 00, assert rst_ni low -> all outputs 0 immediately; no reg_we ever issued.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// Host command bridge: UART byte frames ('W' addr data / 'R' addr) in, register bus strobes out, response bytes back.
// Latency: strobe one cycle after the last frame byte; first response byte one cycle after the strobe (write) or after RD_LAT (read).
// Backpressure: response bytes are held on tx_byte_o until tx_ready_i; rx bytes arriving outside a frame-parsing state are dropped with err_o.
module uart_reg_bridge #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int RD_LAT      = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [11:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int LW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYC);
  localparam logic [LW-1:0] LAT_LIM = LW'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WRITE, S_READ, S_RD_WAIT, S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [11:0]   addr_sh_q, addr_sh_d;
  logic [31:0]   data_sh_q, data_sh_d;
  logic [1:0]    resp_left_q, resp_left_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [11:0]   reg_addr_q, reg_addr_d;
  logic [31:0]   reg_wdata_q, reg_wdata_d;
  logic          reg_we_q, reg_we_d;
  logic          reg_re_q, reg_re_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          in_frame;
  logic          to_exp;
  logic [TW-1:0] to_inc;

  // Next-state and registered-output computation for the frame parser / responder.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    cnt_d       = cnt_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    resp_left_d = resp_left_q;
    to_cnt_d    = '0;
    lat_cnt_d   = lat_cnt_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    tx_byte_d   = tx_byte_q;
    tx_valid_d  = tx_valid_q;
    err_d       = 1'b0;

    in_frame = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);
    to_exp   = (TIMEOUT_CYC != 0) && (to_cnt_q >= TO_LIM);
    to_inc   = (to_cnt_q == {TW{1'b1}}) ? to_cnt_q : to_cnt_q + TW'(1);

    // Bytes arriving while a transaction or response is in flight are discarded.
    if (rx_valid_i && !in_frame && (state_q != S_IDLE)) err_d = 1'b1;

    if (in_frame && to_exp) begin
      // Timeout beats a byte landing on the same cycle; the frame is abandoned silently.
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      if (in_frame) to_cnt_d = rx_valid_i ? '0 : to_inc;
      case (state_q)
        S_IDLE: begin
          if (rx_valid_i) begin
            if (rx_byte_i == 8'h57 || rx_byte_i == 8'h52) begin
              is_wr_d = (rx_byte_i == 8'h57);
              state_d = S_ADDR_HI;
            end else begin
              state_d     = S_RESP;
              tx_byte_d   = 8'h45;
              tx_valid_d  = 1'b1;
              resp_left_d = 2'd0;
              err_d       = 1'b1;
            end
          end
        end
        S_ADDR_HI: begin
          if (rx_valid_i) begin
            addr_sh_d[11:8] = rx_byte_i[3:0];
            state_d         = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (rx_valid_i) begin
            addr_sh_d[7:0] = rx_byte_i;
            if (is_wr_q) begin
              cnt_d   = 2'd0;
              state_d = S_DATA;
            end else begin
              reg_addr_d = {addr_sh_q[11:8], rx_byte_i};
              reg_re_d   = 1'b1;
              state_d    = S_READ;
            end
          end
        end
        S_DATA: begin
          if (rx_valid_i) begin
            data_sh_d = {data_sh_q[23:0], rx_byte_i};
            cnt_d     = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              reg_addr_d  = addr_sh_q;
              reg_wdata_d = {data_sh_q[23:0], rx_byte_i};
              reg_we_d    = 1'b1;
              state_d     = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          tx_byte_d   = 8'h4B;
          tx_valid_d  = 1'b1;
          resp_left_d = 2'd0;
          state_d     = S_RESP;
        end
        S_READ: begin
          lat_cnt_d = LW'(1);
          state_d   = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (lat_cnt_q >= LAT_LIM) begin
            data_sh_d   = reg_rdata;
            tx_byte_d   = reg_rdata[31:24];
            tx_valid_d  = 1'b1;
            resp_left_d = 2'd3;
            state_d     = S_RESP;
          end else begin
            lat_cnt_d = lat_cnt_q + LW'(1);
          end
        end
        S_RESP: begin
          if (tx_valid_q && tx_ready_i) begin
            if (resp_left_q == 2'd0) begin
              tx_valid_d = 1'b0;
              state_d    = S_IDLE;
            end else begin
              data_sh_d   = {data_sh_q[23:0], 8'h00};
              tx_byte_d   = data_sh_q[23:16];
              resp_left_d = resp_left_q - 2'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; async reset aborts any frame without issuing a strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      resp_left_q <= '0;
      to_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      resp_left_q <= resp_left_d;
      to_cnt_q    <= to_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign tx_byte_o  = tx_byte_q;
  assign tx_valid_o = tx_valid_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_re     = reg_re_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: stimulus pushes expected strobes/tx bytes, a negedge monitor pops and compares.
// Latency: checks are order-based, not cycle-exact, except timeout boundaries which are placed on exact cycles.
// Backpressure: tx_ready_i is dropped during one read response to check the held byte.
module tb_uart_reg_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_byte_i;
  logic        rx_valid_i;
  logic [7:0]  tx_byte_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata = 32'h0;
  logic        busy_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  uart_reg_bridge #(.TIMEOUT_CYC(50), .RD_LAT(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i),
    .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy_o(busy_o), .err_o(err_o)
  );

  // Slave model: read data is valid exactly one cycle after reg_re, zero otherwise.
  logic [31:0] rd_val = 32'h0;
  always @(posedge clk_i) reg_rdata <= reg_re ? rd_val : 32'h0;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a strobe or a transferred tx byte.
  logic       hold_prev = 1'b0;
  logic [7:0] hold_byte = 8'h0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold_prev = 1'b0;
    end else begin
      if (err_o) err_seen++;
      if (reg_we || reg_re) begin
        chk("we_re_exclusive", {31'b0, reg_we & reg_re}, 32'h0);
        if (exp_bus.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_strobe: we=%0b re=%0b addr=0x%0h, none expected", reg_we, reg_re, reg_addr);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          chk("strobe_we", {31'b0, reg_we}, {31'b0, e.we});
          chk("strobe_addr", {20'b0, reg_addr}, {20'b0, e.addr});
          if (e.we) chk("strobe_wdata", reg_wdata, e.wdata);
        end
      end
      if (hold_prev) begin
        chk("tx_hold_valid", {31'b0, tx_valid_o}, 32'h1);
        chk("tx_hold_byte", {24'b0, tx_byte_o}, {24'b0, hold_byte});
      end
      if (tx_valid_o && tx_ready_i) begin
        if (exp_tx.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_tx: byte 0x%0h, none expected", tx_byte_o);
        end else begin
          chk("tx_byte", {24'b0, tx_byte_o}, {24'b0, exp_tx.pop_front()});
        end
      end
      hold_prev = tx_valid_o && !tx_ready_i;
      hold_byte = tx_byte_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  // Sends n bytes from a right-justified vector, most significant byte first, one idle cycle apart.
  task automatic send_frame(input logic [55:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      send(v[8*(n-1-i) +: 8]);
      idle(1);
    end
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while (busy_o && i < 400) begin
      @(posedge clk_i);
      #1;
      i++;
    end
    chk(nm, {31'b0, busy_o}, 32'h0);
  endtask

  task automatic exp_write(input logic [11:0] a, input logic [31:0] d);
    exp_bus.push_back('{we: 1'b1, addr: a, wdata: d});
    exp_tx.push_back(8'h4B);
  endtask

  task automatic exp_read(input logic [11:0] a, input logic [31:0] d);
    exp_bus.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
    rd_val = d;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_valid"}, {31'b0, tx_valid_o}, 32'h0);
    chk({tag, "_tx_byte"}, {24'b0, tx_byte_o}, 32'h0);
    chk({tag, "_reg_we"}, {31'b0, reg_we}, 32'h0);
    chk({tag, "_reg_re"}, {31'b0, reg_re}, 32'h0);
    chk({tag, "_reg_addr"}, {20'b0, reg_addr}, 32'h0);
    chk({tag, "_reg_wdata"}, reg_wdata, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
    chk({tag, "_err"}, {31'b0, err_o}, 32'h0);
  endtask

  initial begin
    int i;
    rst_ni = 1'b0;
    rx_byte_i = 8'h0;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    idle(3);
    chk_outputs_zero("reset");
    rst_ni = 1'b1;
    idle(2);

    // Basic write and read.
    exp_write(12'h018, 32'h0000_0005);
    send_frame(56'h57_0018_0000_0005, 7);
    wait_idle("write1_idle");
    exp_read(12'h008, 32'h0000_00A5);
    send_frame(56'h52_0008, 3);
    wait_idle("read1_idle");

    // Upper address nibble of ADDR_HI is ignored.
    exp_write(12'h345, 32'h1234_5678);
    send_frame(56'h57_5345_1234_5678, 7);
    wait_idle("write2_idle");
    exp_read(12'hF12, 32'hDEAD_BEEF);
    send_frame(56'h52_AF12, 3);
    wait_idle("read2_idle");
    idle(2);
    chk("err_after_good", err_seen, err_exp);

    // Bad command byte, then a normal frame.
    exp_tx.push_back(8'h45);
    err_exp++;
    send(8'h33);
    wait_idle("badcmd_idle");
    exp_write(12'hFFF, 32'hAABB_CCDD);
    send_frame(56'h57_0FFF_AABB_CCDD, 7);
    wait_idle("after_bad_idle");
    idle(2);
    chk("err_badcmd", err_seen, err_exp);

    // Timeout after a partial write frame: no strobe, no response.
    err_exp++;
    send(8'h57);
    send(8'h00);
    idle(60);
    chk("timeout_busy", {31'b0, busy_o}, 32'h0);
    chk("timeout_err", err_seen, err_exp);

    // Gaps of 49 idle cycles are still within the limit.
    exp_read(12'h123, 32'h0BAD_F00D);
    send(8'h52);
    idle(49);
    send(8'h01);
    idle(49);
    send(8'h23);
    wait_idle("slow_read_idle");
    idle(2);
    chk("slow_read_err", err_seen, err_exp);

    // Byte landing on the expiry cycle: timeout wins, one pulse, byte dropped.
    err_exp++;
    send(8'h57);
    send(8'h00);
    idle(50);
    send(8'h18);
    idle(5);
    chk("expiry_tie_busy", {31'b0, busy_o}, 32'h0);
    chk("expiry_tie_err", err_seen, err_exp);

    // Backpressured read response with a stray byte dropped mid-response.
    tx_ready_i = 1'b0;
    exp_read(12'h100, 32'h00A5_5A3C);
    send_frame(56'h52_0100, 3);
    i = 0;
    while (!tx_valid_o && i < 100) begin
      @(posedge clk_i);
      #1;
      i++;
    end
    chk("bp_tx_valid", {31'b0, tx_valid_o}, 32'h1);
    idle(3);
    err_exp++;
    send(8'h77);
    idle(6);
    chk("bp_hold_byte", {24'b0, tx_byte_o}, 32'h0);
    tx_ready_i = 1'b1;
    wait_idle("bp_idle");
    idle(2);
    chk("bp_err", err_seen, err_exp);

    // Reset mid-frame: outputs clear at once, the partial write is never issued.
    send(8'h57);
    send(8'h00);
    send(8'h18);
    send(8'h00);
    rst_ni = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    idle(2);
    rst_ni = 1'b1;
    idle(20);
    chk("post_reset_busy", {31'b0, busy_o}, 32'h0);
    exp_read(12'h008, 32'h1234_5678);
    send_frame(56'h52_0008, 3);
    wait_idle("post_reset_read_idle");

    idle(5);
    chk("bus_queue_drained", exp_bus.size(), 32'h0);
    chk("tx_queue_drained", exp_tx.size(), 32'h0);
    chk("err_final", err_seen, err_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
